spi_master: RTL and testbench

- FPGA-side SPI mode-0 master: the initiator end of the channel-strip control link.
- Drives SCLK/CS/MOSI to the SPI slave peripheral and captures MISO.
- One transaction per request: an 8-bit command, then either a 32-bit read (left/right samples) or a 64-bit write (one biquad coefficient).
- Used as the on-chip stand-in for the Raspberry Pi host, for loopback bring-up and for bench self-test.

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_master_if.sv | 31 +++
 rtl/spi_sclk_gen.sv | 42 ++++
 rtl/spi_master.sv | 156 +++++++++++++++
 tb/tb_spi_master.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI control link: command codes, payload
// lengths and the master FSM state encoding. The slave peripheral imports
// this same package.
package spi_pkg;

  localparam logic [7:0] CMD_READ      = 8'h01;
  localparam logic [7:0] CMD_COEF_BASE = 8'h10;
  localparam logic [7:0] CMD_COEF_LAST = 8'h19;

  // Payload lengths in bits; 7 bits covers the 72-bit maximum frame.
  localparam logic [6:0] LEN_READ = 7'd32;
  localparam logic [6:0] LEN_COEF = 7'd64;
  localparam logic [6:0] LEN_NONE = 7'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  // Payload bits following the command byte.
  function automatic logic [6:0] payload_len(input logic [7:0] cmd);
    if (cmd == CMD_READ) begin
      return LEN_READ;
    end else if ((cmd >= CMD_COEF_BASE) && (cmd <= CMD_COEF_LAST)) begin
      return LEN_COEF;
    end else begin
      return LEN_NONE;
    end
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Request/response and SPI pin bundle for spi_master.
// Handshake: start is sampled only while busy=0; an accepted start raises
// busy on the next cycle and busy stays high through the CS-high gap.
// done pulses for one cycle when CS returns high; rdata is then valid.
// A start seen while busy=1 is dropped, never queued.
interface spi_master_if;
  import spi_pkg::*;

  logic        start;
  logic [7:0]  cmd;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        SCLK;
  logic        CS;
  logic        MOSI;
  logic        MISO;
  spi_state_e  state;  // FSM state, exposed for debug/checkers

  modport master (
    input  start, cmd, wdata, MISO,
    output busy, done, rdata, SCLK, CS, MOSI, state
  );

  modport slave (
    output start, cmd, wdata, MISO,
    input  busy, done, rdata, SCLK, CS, MOSI, state
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK divider: counts CLK_DIV cycles per half-period and, when toggling
// is enabled, produces SCLK plus single-cycle rise/fall strobes that mark
// the clock edge on which SCLK changes. The half-period tick also paces
// the non-toggling states (setup, hold, gap).
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_48,
  input  logic reset,
  input  logic i_run,
  input  logic i_toggle,
  output logic o_sclk,
  output logic o_tick,
  output logic o_rise,
  output logic o_fall
);

  logic [7:0] r_div;
  logic       r_sclk;

  assign o_tick = i_run && (r_div == 8'(CLK_DIV - 1));
  assign o_rise = o_tick && i_toggle && !r_sclk;
  assign o_fall = o_tick && i_toggle && r_sclk;
  assign o_sclk = r_sclk;

  // Half-period counter and SCLK phase; both park at zero when idle.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      r_div  <= 8'd0;
      r_sclk <= 1'b0;
    end else if (!i_run) begin
      r_div  <= 8'd0;
      r_sclk <= 1'b0;
    end else begin
      r_div <= o_tick ? 8'd0 : r_div + 8'd1;
      if (o_tick && i_toggle) begin
        r_sclk <= ~r_sclk;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master for the channel-strip control link. One frame per
// request: 8-bit command, then a 32-bit read or 64-bit coefficient write.
// Optional macro SPI_TXN_COUNT_EN adds a 16-bit completed-frame counter.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_HALVES = 2
) (
  input  logic          clk_48,
  input  logic          reset,
`ifdef SPI_TXN_COUNT_EN
  output logic [15:0]   txn_count,
`endif
  spi_master_if.master  bus
);

  spi_state_e  r_state;
  logic [71:0] r_tx;
  logic [31:0] r_rx;
  logic [31:0] r_rdata;
  logic [6:0]  r_bit;
  logic [6:0]  r_len;
  logic [7:0]  r_half;
  logic        r_cs;
  logic        r_done;
  logic        r_is_read;

  logic        w_sclk;
  logic        w_tick;
  logic        w_rise;
  logic        w_fall;
  logic        w_run;
  logic        w_toggle;
  logic [6:0]  w_last_bit;
  logic        w_hold_end;

  assign w_run      = (r_state != ST_IDLE);
  assign w_toggle   = (r_state == ST_CMD) || (r_state == ST_DATA);
  assign w_last_bit = 7'd7 + r_len;
  assign w_hold_end = (r_state == ST_HOLD) && w_tick && (r_half == 8'd1);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk_48   (clk_48),
    .reset    (reset),
    .i_run    (w_run),
    .i_toggle (w_toggle),
    .o_sclk   (w_sclk),
    .o_tick   (w_tick),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  // Frame sequencer: latches the request, shifts MOSI on SCLK falls,
  // captures MISO on SCLK rises and times the hold and gap intervals.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_tx      <= 72'd0;
      r_rx      <= 32'd0;
      r_rdata   <= 32'd0;
      r_bit     <= 7'd0;
      r_len     <= 7'd0;
      r_half    <= 8'd0;
      r_cs      <= 1'b1;
      r_done    <= 1'b0;
      r_is_read <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state   <= ST_SETUP;
            r_cs      <= 1'b0;
            r_bit     <= 7'd0;
            r_len     <= payload_len(bus.cmd);
            r_is_read <= (bus.cmd == CMD_READ);
            // Non-write frames shift zeros after the command byte.
            r_tx      <= (payload_len(bus.cmd) == LEN_COEF) ?
                         {bus.cmd, bus.wdata} : {bus.cmd, 64'd0};
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_state <= ST_CMD;
          end
        end
        ST_CMD, ST_DATA: begin
          if ((r_state == ST_DATA) && r_is_read && w_rise) begin
            r_rx <= {r_rx[30:0], bus.MISO};
          end
          if (w_fall) begin
            r_tx  <= {r_tx[70:0], 1'b0};
            r_bit <= r_bit + 7'd1;
            if (r_bit == w_last_bit) begin
              r_state <= ST_HOLD;
              r_half  <= 8'd0;
              // The final rise precedes this fall, so r_rx is complete.
              if (r_is_read) begin
                r_rdata <= r_rx;
              end
            end else if (r_bit == 7'd7) begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            if (r_half == 8'd1) begin
              r_state <= ST_GAP;
              r_cs    <= 1'b1;
              r_done  <= 1'b1;
              r_half  <= 8'd0;
            end else begin
              r_half <= r_half + 8'd1;
            end
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            if (r_half == 8'(GAP_HALVES - 1)) begin
              r_state <= ST_IDLE;
            end else begin
              r_half <= r_half + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_TXN_COUNT_EN
  logic [15:0] r_txn_count;

  // Completed-frame counter; bumps in step with the done pulse and wraps.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      r_txn_count <= 16'd0;
    end else if (w_hold_end) begin
      r_txn_count <= r_txn_count + 16'd1;
    end
  end

  assign txn_count = r_txn_count;
`endif

  assign bus.busy  = w_run;
  assign bus.done  = r_done;
  assign bus.rdata = r_rdata;
  assign bus.SCLK  = w_sclk;
  assign bus.CS    = r_cs;
  assign bus.MOSI  = r_tx[71];
  assign bus.state = r_state;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master with a behavioural mode-0 slave. Build with
// SPI_TXN_COUNT_EN defined to also exercise the frame counter.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int CLK_DIV    = 4;
  localparam int GAP_HALVES = 2;
  localparam int GAP_CYC    = GAP_HALVES * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic clk_48 = 1'b0;
  logic reset;
  initial forever #5 clk_48 = ~clk_48;

  spi_master_if bus();
`ifdef SPI_TXN_COUNT_EN
  logic [15:0] txn_count;
`endif

  spi_master #(.CLK_DIV(CLK_DIV), .GAP_HALVES(GAP_HALVES)) dut (
    .clk_48    (clk_48),
    .reset     (reset),
`ifdef SPI_TXN_COUNT_EN
    .txn_count (txn_count),
`endif
    .bus       (bus)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic [15:0] lat;
    logic [7:0]  rises;
    logic [71:0] mosi;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          m_idle = 1'b1;
  int          m_cnt  = 0;
  int          m_total = 0;
  logic [31:0] m_rdata = 32'd0;
  logic [15:0] m_txn   = 16'd0;
  bit          chk_b2b = 1'b0;

  logic [7:0]  p_cmd   = 8'd0;
  logic [63:0] p_wdata = 64'd0;
  int          p_lat   = 0;
  logic [31:0] slave_resp = 32'd0;

  int          rises  = 0;
  logic [71:0] mosi_sh = 72'd0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural slave ----------------
  // Shifts the response out on SCLK falls, MSB first, after the command byte.
  initial begin
    int  falls;
    logic sclk_prev;
    falls = 0;
    sclk_prev = 1'b0;
    bus.MISO = 1'b0;
    forever begin
      @(bus.CS or bus.SCLK);
      if (bus.CS !== 1'b0) begin
        falls = 0;
        bus.MISO = 1'b0;
      end else if (!bus.SCLK && sclk_prev) begin
        falls++;
        if (falls >= 8 && falls <= 39) bus.MISO = slave_resp[39 - falls];
        else bus.MISO = 1'b0;
      end
      sclk_prev = bus.SCLK;
    end
  end

  // Counts SCLK rises and collects MOSI bits within each CS-low frame.
  initial begin
    forever begin
      @(posedge bus.SCLK or negedge bus.CS);
      if (!bus.SCLK) begin
        rises = 0;
        mosi_sh = 72'd0;
      end else if (!bus.CS) begin
        rises++;
        mosi_sh = {mosi_sh[70:0], bus.MOSI};
      end
    end
  end

  // ---------------- acceptance model ----------------
  // Decides from bench state alone when a start is accepted, pushes the
  // expected response, and tracks when the DUT must be idle again.
  initial begin
    int   n;
    exp_t e;
    forever begin
      @(posedge clk_48 or posedge reset);
      if (reset) begin
        m_idle = 1'b1;
        exp_q.delete();
        acc_q.delete();
        m_rdata = 32'd0;
        m_txn = 16'd0;
      end else begin
        cyc++;
        if (!m_idle) begin
          m_cnt++;
          if (m_cnt == m_total) begin
            m_idle = 1'b1;
            check("done_seen_before_idle", 72'(exp_q.size()), 72'd0);
            exp_q.delete();
            acc_q.delete();
          end
        end else if (bus.start) begin
          m_idle = 1'b0;
          m_cnt = 0;
          m_total = p_lat - 1 + GAP_CYC;
          n = (p_cmd == 8'h01) ? 32 : ((p_cmd >= 8'h10 && p_cmd <= 8'h19) ? 64 : 0);
          if (p_cmd == 8'h01) m_rdata = slave_resp;
          e.rdata = m_rdata;
          e.lat = 16'(p_lat);
          e.rises = 8'(8 + n);
          if (n == 64) e.mosi = {p_cmd, p_wdata};
          else if (n == 32) e.mosi = {32'h0, p_cmd, 32'h0};
          else e.mosi = {64'h0, p_cmd};
          exp_q.push_back(e);
          acc_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int   run;
    bit   armed;
    int   a;
    exp_t e;
    run = 0;
    armed = 1'b0;
    forever begin
      @(posedge clk_48);
      #1;
      if (!reset) begin
        check("busy", 72'(bus.busy), 72'(!m_idle));
        if (bus.CS) check("sclk_low_while_cs_high", 72'(bus.SCLK), 72'd0);
        if (bus.CS) run++;
        else begin
          if (armed) check("cs_gap_cycles", 72'(run), 72'(GAP_CYC + 1));
          armed = 1'b0;
          run = 0;
        end
        if (!chk_b2b) armed = 1'b0;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("latency", 72'(cyc - a + 1), 72'(e.lat));
            check("sclk_rises", 72'(rises), 72'(e.rises));
            check("mosi_bits", mosi_sh, e.mosi);
            check("rdata", 72'(bus.rdata), 72'(e.rdata));
            check("cs_high_at_done", 72'(bus.CS), 72'd1);
`ifdef SPI_TXN_COUNT_EN
            check("txn_count", 72'(txn_count), 72'(m_txn + 16'd1));
            m_txn = m_txn + 16'd1;
`endif
            armed = chk_b2b;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk_48);
    while (!m_idle && n < max_cyc) begin
      @(negedge clk_48);
      n++;
    end
    if (!m_idle) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles", max_cyc);
    end
  endtask

  task automatic issue(input logic [7:0] c, input logic [63:0] w,
                       input logic [31:0] resp, input int lat);
    wait_idle(2000);
    p_cmd = c;
    p_wdata = w;
    p_lat = lat;
    slave_resp = resp;
    bus.cmd = c;
    bus.wdata = w;
    bus.start = 1'b1;
    @(negedge clk_48);
    bus.start = 1'b0;
    // Scramble the request lines to prove the DUT latched them.
    bus.cmd = ~c;
    bus.wdata = ~w;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cmd = 8'd0;
    bus.wdata = 64'd0;
    repeat (3) @(negedge clk_48);
    check("rst_cs", 72'(bus.CS), 72'd1);
    check("rst_sclk", 72'(bus.SCLK), 72'd0);
    check("rst_mosi", 72'(bus.MOSI), 72'd0);
    check("rst_busy", 72'(bus.busy), 72'd0);
    check("rst_done", 72'(bus.done), 72'd0);
    check("rst_rdata", 72'(bus.rdata), 72'd0);
    reset = 1'b0;

    issue(8'h01, 64'h0, 32'h1234FEDC, 333);
    issue(8'h12, 64'h0123456789ABCDEF, 32'h0, 589);
    issue(8'h55, 64'h0, 32'h0, 77);
    issue(8'h1A, 64'hDEADBEEF00000000, 32'h0, 77);
    issue(8'h10, 64'hFFFF0000A5A55A5A, 32'h0, 589);

    // start while busy is dropped
    issue(8'h01, 64'h0, 32'h8001_7FFE, 333);
    repeat (50) @(negedge clk_48);
    bus.cmd = 8'h55;
    bus.start = 1'b1;
    @(negedge clk_48);
    bus.start = 1'b0;

    // start held high for 1000 cycles: back-to-back command-only frames
    wait_idle(2000);
    p_cmd = 8'h55;
    p_wdata = 64'h0;
    p_lat = 77;
    bus.cmd = 8'h55;
    chk_b2b = 1'b1;
    bus.start = 1'b1;
    repeat (1000) @(negedge clk_48);
    bus.start = 1'b0;
    wait_idle(2000);
    chk_b2b = 1'b0;

    // asynchronous abort 150 cycles into a read
    issue(8'h01, 64'h0, 32'hCAFEBABE, 333);
    repeat (149) @(posedge clk_48);
    #3;
    reset = 1'b1;
    #1;
    check("abort_cs", 72'(bus.CS), 72'd1);
    check("abort_sclk", 72'(bus.SCLK), 72'd0);
    check("abort_busy", 72'(bus.busy), 72'd0);
    check("abort_done", 72'(bus.done), 72'd0);
    check("abort_mosi", 72'(bus.MOSI), 72'd0);
    check("abort_rdata", 72'(bus.rdata), 72'd0);
`ifdef SPI_TXN_COUNT_EN
    check("abort_txn_count", 72'(txn_count), 72'd0);
`endif
    @(negedge clk_48);
    reset = 1'b0;
    repeat (400) @(negedge clk_48);
    check("rdata_after_abort", 72'(bus.rdata), 72'd0);
    issue(8'h01, 64'h0, 32'hA5C30F1E, 333);

`ifdef SPI_TXN_COUNT_EN
    wait_idle(2000);
    force dut.r_txn_count = 16'hFFFF;
    @(negedge clk_48);
    release dut.r_txn_count;
    m_txn = 16'hFFFF;
    issue(8'h55, 64'h0, 32'h0, 77);
    wait_idle(2000);
    check("txn_count_wrapped", 72'(txn_count), 72'd0);
`endif

    wait_idle(2000);
    repeat (20) @(negedge clk_48);
    check("scoreboard_empty", 72'(exp_q.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
